// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch state encoding, PC reset vector.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Address the PC starts from after reset
    localparam logic [7:0] PC_RESET_VEC = 8'h00;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetches the word at pc_addr over a req/ack memory
// handshake, presents it to the decoder over valid/ready, and drives the PC
// with either the sequential next address or a branch redirect.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_en,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic               branch_req,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_VEC);

    fetch_state_e        state_q,    state_d;
    logic                squash_q,   squash_d;
    logic                ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0]  ir_data_q,  ir_data_d;
    logic [ADDR_W-1:0]   ir_pc_q,    ir_pc_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                pc_en_s;
    logic [ADDR_W-1:0]   pc_next_s;

    // Next-state, registered-output next values and combinational PC control
    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        ir_valid_d  = ir_valid_q;
        ir_data_d   = ir_data_q;
        ir_pc_d     = ir_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        pc_en_s     = 1'b0;
        pc_next_s   = RESET_ADDR;

        case (state_q)
            ST_IDLE: begin
                if (branch_req) begin
                    // Redirect; spend another bubble so the new PC is visible
                    pc_en_s   = 1'b1;
                    pc_next_s = branch_target;
                    state_d   = ST_IDLE;
                end else begin
                    state_d     = ST_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_addr;
                end
            end

            ST_REQ: begin
                if (imem_ack) begin
                    // Request completes in every ack case; default is to drop
                    imem_req_d = 1'b0;
                    squash_d   = 1'b0;
                    state_d    = ST_IDLE;
                    if (branch_req) begin
                        pc_en_s   = 1'b1;
                        pc_next_s = branch_target;
                    end else if (squash_q) begin
                        // Stale data from a fetch overtaken by a branch
                        pc_en_s = 1'b0;
                    end else begin
                        ir_data_d  = imem_rdata;
                        ir_pc_d    = imem_addr_q;
                        ir_valid_d = 1'b1;
                        pc_en_s    = 1'b1;
                        pc_next_s  = imem_addr_q + ADDR_W'(1);
                        state_d    = ST_HOLD;
                    end
                end else if (branch_req) begin
                    // Request cannot be withdrawn: remember to discard its data
                    squash_d  = 1'b1;
                    pc_en_s   = 1'b1;
                    pc_next_s = branch_target;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (branch_req) begin
                    // Held instruction is on the wrong path; drop it
                    pc_en_s    = 1'b1;
                    pc_next_s  = branch_target;
                    ir_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (ir_valid_q && ir_ready) begin
                    // PC already advanced at ack time, fetch straight away
                    ir_valid_d  = 1'b0;
                    state_d     = ST_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_addr;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                squash_d   = 1'b0;
                ir_valid_d = 1'b0;
                imem_req_d = 1'b0;
            end
        endcase

        if (rst) begin
            pc_en_s   = 1'b0;
            pc_next_s = RESET_ADDR;
        end else begin
            pc_en_s   = pc_en_s;
            pc_next_s = pc_next_s;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            squash_q    <= 1'b0;
            ir_valid_q  <= 1'b0;
            ir_data_q   <= '0;
            ir_pc_q     <= RESET_ADDR;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            ir_valid_q  <= ir_valid_d;
            ir_data_q   <= ir_data_d;
            ir_pc_q     <= ir_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign pc_en     = pc_en_s;
    assign pc_next   = pc_next_s;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign ir_valid  = ir_valid_q;
    assign ir_data   = ir_data_q;
    assign ir_pc     = ir_pc_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly downstream of the program counter.
- Takes the current PC value, fetches the instruction word from instruction memory over a req/ack handshake, and holds it in the instruction register for the decoder under a valid/ready handshake.
- Drives the PC's load strobe and next-address value: sequential increment, or branch redirect.
- Squashes in-flight fetches on a branch.

Parameters:
- ADDR_W, 8, width of PC / instruction address.
- INSTR_W, 16, width of instruction word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_addr  in  ADDR_W  current PC value from program counter.
- pc_en  out  1  PC load strobe; PC takes pc_next at the next clk edge.
- pc_next  out  ADDR_W  value for PC to load.
- branch_req  in  1  single-cycle redirect request from execute.
- branch_target  in  ADDR_W  redirect address, valid with branch_req.
- imem_req  out  1  instruction memory request, level.
- imem_addr  out  ADDR_W  fetch address, valid while imem_req=1.
- imem_ack  in  1  single-cycle completion from memory.
- imem_rdata  in  INSTR_W  instruction word, valid with imem_ack.
- ir_valid  out  1  instruction register holds a live instruction.
- ir_ready  in  1  decoder accepts the instruction.
- ir_data  out  INSTR_W  instruction register contents.
- ir_pc  out  ADDR_W  address the instruction was fetched from.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE, squash=0.
  - ir_valid=0, ir_data=0, ir_pc=0, imem_req=0, imem_addr=0.
  - pc_en and pc_next are forced to 0 while rst=1.
  - An imem_ack arriving in the cycle after reset is ignored (state is IDLE).
- State machine: IDLE, REQ, HOLD.
  - IDLE: one-cycle bubble so any PC update is visible on pc_addr; next state is REQ.
  - REQ:
    - imem_req=1 and imem_addr=pc_addr, captured on entry and held constant until ack.
    - On imem_ack with squash=0 and no branch_req:
      - ir_data<=imem_rdata, ir_pc<=imem_addr, ir_valid<=1.
      - pc_en=1 and pc_next=imem_addr+1 that cycle, modulo 2^ADDR_W, so 0xFF wraps to 0x00.
      - Next state HOLD.
  - HOLD:
    - ir_valid=1 and ir_data is held stable until ir_valid&&ir_ready.
    - On transfer: ir_valid<=0, next state REQ. pc_addr already holds the incremented PC by then.
    - Minimum throughput: one instruction per 2 cycles plus memory latency.
- Branch (branch_req=1, any non-reset state):
  - pc_en=1 and pc_next=branch_target that cycle. Branch wins over the sequential increment.
  - IDLE: stay IDLE for the cycle, then REQ with the new pc_addr.
  - REQ with no ack this cycle: set squash=1 and keep imem_req high (the memory protocol forbids withdrawing a request). On the eventual ack, discard data, no pc_en, clear squash, go to IDLE.
  - REQ with ack in the same cycle: discard data, no ir update, go to IDLE.
  - HOLD: ir_valid<=0 next cycle and the instruction is dropped, even if ir_ready=1 that cycle. Go to IDLE.
- Ack while squash=1 and a new branch_req in the same cycle: data discarded, pc_next=new target, go to IDLE.
- A second branch_req while squash=1 with no ack: pc_en=1 with the newer target; squash stays 1.
- imem_ack outside REQ is ignored.
- pc_en is never asserted for more than one cycle per fetch or branch event.

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W/INSTR_W defaults.
  - Fetch state enum {IDLE, REQ, HOLD}.
  - PC reset vector constant (0x00).
- Single module; no sub-module is natural.
- pc_next/pc_en is combinational from state, imem_ack, squash and branch_req. All other outputs are registered.

Test Plan:
- Reset then release with pc_addr=0x00 and memory acking 1 cycle after req, returning 0xA001:
  - IDLE for 1 cycle, then imem_req=1 with imem_addr=0x00.
  - On ack: pc_en=1 and pc_next=0x01; next cycle ir_valid=1, ir_data=0xA001, ir_pc=0x00.
- Decoder holds ir_ready=0 for 5 cycles:
  - ir_valid and ir_data stay stable, imem_req=0.
  - When ready rises, next fetch issues from 0x01.
- pc_addr=0xFF fetch acked: pc_next=0x00, pc_en=1.
- branch_req with target 0x40 during REQ, ack arriving 3 cycles later with 0xBEEF:
  - pc_en=1 and pc_next=0x40 in the branch cycle.
  - Ack data dropped, ir_valid stays 0.
  - Next imem_addr=0x40.
- branch_req with target 0x10 in the same cycle as ack: pc_next=0x10, no ir update, next fetch from 0x10.
- rst=1 asserted in HOLD with ir_valid=1:
  - Next cycle ir_valid=0, imem_req=0, ir_data=0.
  - A stray imem_ack in the following cycle causes no state change.
